// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite master arbiter.
// Contents: controller state encoding, op encoding, width helper.
package axil_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // Bits needed to index/count up to value-1, never less than 1.
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned r;
      r = 0;
      while (((32'd1 << r) < value) && (r < 31)) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first set bit of req_valid searching
// upward from rr_ptr with wrap.
// Ports: req_valid (request vector), rr_ptr (search start),
//        grant (one-hot, zero when no request), grant_idx (binary index).
module rr_grant
   import axil_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int unsigned off = NUM_REQ; off > 0; off--) begin
         int unsigned cand;
         cand = 32'(rr_ptr) + off - 1;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (req_valid[IDX_W'(cand)]) begin
            grant                = '0;
            grant[IDX_W'(cand)]  = 1'b1;
            grant_idx            = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master engine among NUM_REQ
// requesters. One single-beat transaction at a time, enable dropped for a
// RELEASE cycle after every completion, per-transaction timeout.
// Ports: req_* (requester commands, req_ready accept pulse),
//        rsp_* (one-hot completion pulse, read data, timeout flag), busy,
//        read_/write_* (engine command interface and done pulses).
module axil_master_arbiter
   import axil_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_areset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      read_ena,
   output logic                      write_ena,
   output logic [ADDR_W-1:0]         read_addr,
   output logic [ADDR_W-1:0]         write_addr,
   output logic [DATA_W-1:0]         write_data,
   input  logic [DATA_W-1:0]         read_data,
   input  logic                      read_done,
   input  logic                      write_done
);

   localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
   localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                read_ena_q, read_ena_d;
   logic                write_ena_q, write_ena_d;
   logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
   logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
   logic [DATA_W-1:0]   write_data_q, write_data_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
   logic                done_match;
   logic                timeout_hit;

   rr_grant #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_grant (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Unpack per-requester fields.
   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
      end
   end

   // Accept pulse is same-cycle with the grant; suppressed while in reset.
   assign req_ready = (state_q == IDLE && !m_axi_areset) ? grant : '0;

   assign done_match  = (op_q == OP_WR) ? write_done : read_done;
   // Fires in the ISSUE cycle that brings the count to TIMEOUT_CYC.
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_idx_d    = gnt_idx_q;
      cnt_d        = cnt_q;
      read_ena_d   = read_ena_q;
      write_ena_d  = write_ena_q;
      read_addr_d  = read_addr_q;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = '0;
      rsp_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               gnt_idx_d = grant_idx;
               cnt_d     = '0;
               rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
               if (req_write[grant_idx]) begin
                  op_d         = OP_WR;
                  write_ena_d  = 1'b1;
                  write_addr_d = addr_arr[grant_idx];
                  write_data_d = wdata_arr[grant_idx];
                  read_addr_d  = '0;
               end else begin
                  op_d         = OP_RD;
                  read_ena_d   = 1'b1;
                  read_addr_d  = addr_arr[grant_idx];
                  write_addr_d = '0;
                  write_data_d = '0;
               end
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            // Done has priority over a coincident timeout.
            if (done_match || timeout_hit) begin
               read_ena_d   = 1'b0;
               write_ena_d  = 1'b0;
               read_addr_d  = '0;
               write_addr_d = '0;
               write_data_d = '0;
               rsp_valid_d  = NUM_REQ'(1) << gnt_idx_q;
               if (done_match) begin
                  rsp_rdata_d = (op_q == OP_RD) ? read_data : '0;
               end else begin
                  rsp_err_d = 1'b1;
               end
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         state_q      <= IDLE;
         op_q         <= OP_RD;
         rr_ptr_q     <= '0;
         gnt_idx_q    <= '0;
         cnt_q        <= '0;
         read_ena_q   <= 1'b0;
         write_ena_q  <= 1'b0;
         read_addr_q  <= '0;
         write_addr_q <= '0;
         write_data_q <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_idx_q    <= gnt_idx_d;
         cnt_q        <= cnt_d;
         read_ena_q   <= read_ena_d;
         write_ena_q  <= write_ena_d;
         read_addr_q  <= read_addr_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign read_ena   = read_ena_q;
   assign write_ena  = write_ena_q;
   assign read_addr  = read_addr_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Self-checking bench for axil_master_arbiter (4 requesters, timeout 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 units after it. The engine is a small behavioural model in the bench.
module tb_axil_master_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [DW-1:0]     rsp_rdata, write_data, read_data;
   logic              rsp_err, busy, read_ena, write_ena, read_done, write_done;
   logic [AW-1:0]     read_addr, write_addr;

   int checks   = 0;
   int failures = 0;

   // engine model controls: done on the (eng_lat+1)-th enabled cycle
   int          eng_cnt  = 0;
   int          eng_lat  = 1000;
   int          eng_spur = 0;
   logic [DW-1:0] eng_data = '0;

   always #5 clk = ~clk;

   axil_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .m_axi_aclk   (clk),
      .m_axi_areset (rst),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .busy         (busy),
      .read_ena     (read_ena),
      .write_ena    (write_ena),
      .read_addr    (read_addr),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_data    (read_data),
      .read_done    (read_done),
      .write_done   (write_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to the drive phase of the next cycle and run the engine model.
   task automatic tick();
      @(posedge clk);
      #1;
      if (read_ena || write_ena) eng_cnt++;
      else eng_cnt = 0;
      read_done  = 1'b0;
      write_done = 1'b0;
      read_data  = '0;
      if (eng_cnt != 0 && eng_cnt == eng_lat + 1) begin
         if (read_ena) begin
            read_done = 1'b1;
            read_data = eng_data;
         end else begin
            write_done = 1'b1;
         end
      end else if (eng_cnt != 0 && eng_cnt == eng_spur) begin
         // wrong-direction pulse; must be ignored
         if (read_ena) write_done = 1'b1;
         else begin
            read_done = 1'b1;
            read_data = 32'hBAD0BAD0;
         end
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_valid  = '0;
      req_write  = '0;
      req_addr   = '0;
      req_wdata  = '0;
      read_done  = 1'b0;
      write_done = 1'b0;
      read_data  = '0;
      eng_cnt    = 0;
      eng_spur   = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Called in drive phase; returns at sample phase of the ready cycle.
   task automatic wait_ready(output logic [N-1:0] got);
      got = '0;
      for (int i = 0; i < 60; i++) begin
         #2;
         if (req_ready != '0) begin
            got = req_ready;
            return;
         end
         tick();
      end
   endtask

   task automatic wait_rsp(output logic [N-1:0] v, output logic [DW-1:0] d, output logic e);
      v = '0; d = '0; e = 1'b0;
      for (int i = 0; i < 60; i++) begin
         #2;
         if (rsp_valid != '0) begin
            v = rsp_valid; d = rsp_rdata; e = rsp_err;
            return;
         end
         tick();
      end
   endtask

   // Observe 18 cycles after a grant (called at sample phase of grant cycle).
   task automatic issue_window(input logic [N-1:0] clear_mask, output int rk,
                               output logic [N-1:0] rv, output logic [DW-1:0] rd,
                               output logic re, output int ena_cnt, output logic [N-1:0] rdy18);
      rk = 0; rv = '0; rd = '0; re = 1'b0; ena_cnt = 0; rdy18 = '0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 1) req_valid = req_valid & ~clear_mask;
         #2;
         if (read_ena || write_ena) ena_cnt++;
         if (rsp_valid != '0 && rk == 0) begin
            rk = k; rv = rsp_valid; rd = rsp_rdata; re = rsp_err;
         end
         if (k == 18) rdy18 = req_ready;
      end
   endtask

   typedef struct {
      logic [N-1:0]  valid;
      logic [N-1:0]  ready;
      logic          ren;
      logic          wen;
      logic [AW-1:0] raddr;
      logic [N-1:0]  rspv;
      logic [DW-1:0] rdata;
      logic          err;
      logic          bsy;
   } vec_t;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t          tbl [9];
      logic [N-1:0]  got, rv;
      logic [DW-1:0] rd;
      logic          re;
      int            rk, ena_cnt;
      logic [N-1:0]  rdy18;

      // ---------------- reset state ----------------
      rst = 1'b0;
      req_valid = '1; req_write = '0; req_addr = '1; req_wdata = '1;
      read_done = 1'b0; write_done = 1'b0; read_data = '0;
      #1 rst = 1'b1;
      #2;
      chk("reset req_ready", 64'(req_ready), 64'(0));
      chk("reset busy/ena", {busy, read_ena, write_ena}, 3'b000);
      chk("reset addrs", {read_addr, write_addr}, 64'(0));
      chk("reset wdata/rsp", {write_data, rsp_rdata}, 64'(0));
      chk("reset rsp_valid/err", {rsp_valid, rsp_err}, 5'b0);

      // ---------------- single read (table driven) ----------------
      do_reset();
      set_req(0, 1'b0, 1'b0, 32'h40, 32'h0);
      eng_lat  = 5;
      eng_data = 32'hDEADBEEF;
      tbl[0] = '{valid:4'b0001, ready:4'b0001, ren:0, wen:0, raddr:0,
                 rspv:0, rdata:0, err:0, bsy:0};
      for (int i = 1; i <= 6; i++)
         tbl[i] = '{valid:4'b0000, ready:4'b0000, ren:1, wen:0, raddr:32'h40,
                    rspv:0, rdata:0, err:0, bsy:1};
      tbl[7] = '{valid:4'b0000, ready:4'b0000, ren:0, wen:0, raddr:0,
                 rspv:4'b0001, rdata:32'hDEADBEEF, err:0, bsy:1};
      tbl[8] = '{valid:4'b0000, ready:4'b0000, ren:0, wen:0, raddr:0,
                 rspv:0, rdata:0, err:0, bsy:0};
      for (int i = 0; i < 9; i++) begin
         tick();
         req_valid = tbl[i].valid;
         #2;
         chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(tbl[i].ready));
         chk($sformatf("vec%0d ena r/w", i), {read_ena, write_ena}, {tbl[i].ren, tbl[i].wen});
         chk($sformatf("vec%0d read_addr", i), 64'(read_addr), 64'(tbl[i].raddr));
         chk($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rspv));
         chk($sformatf("vec%0d rsp_rdata/err", i), {rsp_rdata, rsp_err}, {tbl[i].rdata, tbl[i].err});
         chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
      end

      // ---------------- round robin ----------------
      do_reset();
      eng_lat = 2;
      for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 1'b0, AW'(32'h100 * i), 32'h0);
      for (int n = 0; n < 5; n++) begin
         if (n > 0) tick();
         wait_ready(got);
         chk($sformatf("rr grant %0d", n), 64'(got), 64'(4'b0001 << (n % 4)));
      end

      // ---------------- mixed read/write ----------------
      do_reset();
      eng_lat  = 3;
      eng_data = 32'hCAFEF00D;
      set_req(1, 1'b1, 1'b1, 32'h10, 32'h12345678);
      set_req(2, 1'b1, 1'b0, 32'h20, 32'h0);
      wait_ready(got);
      chk("mix grant write", 64'(got), 64'(4'b0010));
      tick();
      req_valid[1] = 1'b0;
      #2;
      chk("mix write ena", {read_ena, write_ena}, 2'b01);
      chk("mix write addr/data", {write_addr, write_data}, {32'h10, 32'h12345678});
      chk("mix write read_addr", 64'(read_addr), 64'(0));
      tick();
      wait_rsp(rv, rd, re);
      chk("mix write rsp", {rv, rd, re}, {4'b0010, 32'h0, 1'b0});
      tick();
      wait_ready(got);
      chk("mix grant read", 64'(got), 64'(4'b0100));
      tick();
      req_valid[2] = 1'b0;
      #2;
      chk("mix read ena", {read_ena, write_ena}, 2'b10);
      chk("mix read addr", {read_addr, write_addr, write_data}, {32'h20, 32'h0, 32'h0});
      tick();
      wait_rsp(rv, rd, re);
      chk("mix read rsp", {rv, rd, re}, {4'b0100, 32'hCAFEF00D, 1'b0});

      // ---------------- timeout, next requester served ----------------
      do_reset();
      eng_lat = 1000;
      set_req(0, 1'b1, 1'b0, 32'h80, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h84, 32'h0);
      wait_ready(got);
      chk("to grant", 64'(got), 64'(4'b0001));
      issue_window(4'b0001, rk, rv, rd, re, ena_cnt, rdy18);
      chk("to ena cycles", 64'(ena_cnt), 64'(16));
      chk("to rsp cycle", 64'(rk), 64'(17));
      chk("to rsp", {rv, rd, re}, {4'b0001, 32'h0, 1'b1});
      chk("to next grant", 64'(rdy18), 64'(4'b0010));

      // ---------------- done exactly at timeout: done wins ----------------
      do_reset();
      eng_lat  = 15;
      eng_data = 32'h5A5A1234;
      set_req(0, 1'b1, 1'b0, 32'h90, 32'h0);
      wait_ready(got);
      issue_window(4'b0001, rk, rv, rd, re, ena_cnt, rdy18);
      chk("coll rsp cycle", 64'(rk), 64'(17));
      chk("coll rsp", {rv, rd, re}, {4'b0001, 32'h5A5A1234, 1'b0});

      // ---------------- done one cycle too late: timeout ----------------
      do_reset();
      eng_lat  = 16;
      eng_data = 32'h77778888;
      set_req(0, 1'b1, 1'b0, 32'h94, 32'h0);
      wait_ready(got);
      issue_window(4'b0001, rk, rv, rd, re, ena_cnt, rdy18);
      chk("late rsp cycle", 64'(rk), 64'(17));
      chk("late rsp", {rv, rd, re}, {4'b0001, 32'h0, 1'b1});

      // ---------------- reset mid-ISSUE ----------------
      do_reset();
      eng_lat = 1000;
      set_req(2, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
      wait_ready(got);
      chk("rst grant 2", 64'(got), 64'(4'b0100));
      tick();
      req_valid[2] = 1'b0;
      tick();
      #1;
      chk("rst pre write_ena", 64'(write_ena), 64'(1));
      set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
      set_req(3, 1'b1, 1'b0, 32'h48, 32'h0);
      rst = 1'b1;
      #1;
      chk("rst async ena/busy", {read_ena, write_ena, busy}, 3'b000);
      chk("rst async addr/data", {write_addr, write_data, read_addr}, 96'h0);
      chk("rst async ready/rsp", {req_ready, rsp_valid, rsp_err}, 9'h0);
      tick();
      tick();
      rst = 1'b0;
      wait_ready(got);
      chk("rst first grant", 64'(got), 64'(4'b0001));
      chk("rst no rsp", 64'(rsp_valid), 64'(0));

      // ---------------- randomized against transaction-level model ----------------
      do_reset();
      begin
         logic [N-1:0]  pend;
         logic [N-1:0]  pw;
         logic [AW-1:0] pa [N];
         logic [DW-1:0] pd [N];
         int            mptr, next_idle, rsp_cyc, g_cyc, g_idx, clear_idx, lat, k;
         logic          g_wr, exp_err;
         logic [AW-1:0] g_a;
         logic [DW-1:0] g_d, exp_rd;
         pend = '0; pw = '0;
         for (int i = 0; i < int'(N); i++) begin pa[i] = '0; pd[i] = '0; end
         mptr = 0; next_idle = 0; rsp_cyc = -1; g_cyc = -100; g_idx = 0;
         clear_idx = -1; g_wr = 1'b0; g_a = '0; g_d = '0; exp_rd = '0; exp_err = 1'b0;
         for (int t = 0; t < 1500; t++) begin
            if (t > 0) tick();
            if (clear_idx >= 0) begin
               pend[clear_idx] = 1'b0;
               clear_idx = -1;
            end
            for (int i = 0; i < int'(N); i++) begin
               if (pend[i] && $urandom_range(0, 99) < 3) pend[i] = 1'b0;
               else if (!pend[i] && $urandom_range(0, 99) < 30) begin
                  pend[i] = 1'b1;
                  pw[i]   = 1'($urandom_range(0, 1));
                  pa[i]   = $urandom;
                  pd[i]   = $urandom;
               end
               set_req(i, pend[i], pw[i], pa[i], pd[i]);
            end
            #2;
            if (t == rsp_cyc)
               chk("rnd rsp", {rsp_valid, rsp_rdata, rsp_err},
                   {4'(4'b0001 << g_idx), exp_rd, exp_err});
            else
               chk("rnd rsp quiet", 64'(rsp_valid), 64'(0));
            chk("rnd ena", {read_ena, write_ena},
                {(t > g_cyc && t < rsp_cyc && !g_wr), (t > g_cyc && t < rsp_cyc && g_wr)});
            if (t == g_cyc + 1) begin
               if (g_wr) chk("rnd wr cmd", {write_addr, write_data, read_addr}, {g_a, g_d, 32'h0});
               else      chk("rnd rd cmd", {read_addr, write_addr, write_data}, {g_a, 32'h0, 32'h0});
            end
            if (t >= next_idle) begin
               chk("rnd busy idle", 64'(busy), 64'(0));
               if (pend != '0) begin
                  g_idx = -1;
                  for (int off = 0; off < int'(N) && g_idx < 0; off++)
                     if (pend[(mptr + off) % N]) g_idx = (mptr + off) % N;
                  chk("rnd grant", 64'(req_ready), 64'(4'b0001 << g_idx));
                  g_cyc    = t;
                  g_wr     = pw[g_idx];
                  g_a      = pa[g_idx];
                  g_d      = pd[g_idx];
                  lat      = $urandom_range(0, 19);
                  eng_lat  = lat;
                  eng_data = $urandom;
                  eng_spur = $urandom_range(0, 20);
                  exp_err  = (lat + 1 > int'(TO));
                  k        = exp_err ? int'(TO) : lat + 1;
                  exp_rd   = (!exp_err && !g_wr) ? eng_data : '0;
                  rsp_cyc  = t + k + 1;
                  next_idle = rsp_cyc + 1;
                  mptr     = (g_idx + 1) % N;
                  clear_idx = g_idx;
               end else begin
                  chk("rnd no grant", 64'(req_ready), 64'(0));
               end
            end else begin
               chk("rnd ready busy", {req_ready, busy}, 5'b00001);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Shares one AXI4-Lite master engine between NUM_REQ independent requesters using round-robin arbitration.
- Sits between client logic (register pollers, DMA descriptor fetchers, config loaders) and the master engine's simple command interface (read_ena/write_ena, addresses, data, done pulses).
- Sequences one single-beat transaction at a time. Drops the engine enable after each completion so the engine returns to its address state, and never re-issues automatically.
- Adds a per-transaction timeout so a hung slave cannot lock out the other requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 1024, cycles allowed in ISSUE before abort; 0 disables the timeout.

Ports:
- m_axi_aclk  in  1  single clock.
- m_axi_areset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes and errors).
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- read_ena  out  1  to engine.
- write_ena  out  1  to engine.
- read_addr  out  ADDR_W  to engine.
- write_addr  out  ADDR_W  to engine.
- write_data  out  DATA_W  to engine.
- read_data  in  DATA_W  from engine.
- read_done  in  1  from engine, one-cycle pulse.
- write_done  in  1  from engine, one-cycle pulse.

Behaviour:
- Reset (async, m_axi_areset=1):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, busy, both enables, addresses, write_data.
  - Reset mid-transaction aborts silently. No rsp_valid is issued, and the engine sees its enable drop, which resets it.
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Same cycle: req_ready[g]=1.
  - Latch g, the op type, addr and wdata into registers. Drive read_addr or write_addr (and write_data) from those registers. The unused direction's address and data stay 0.
  - rr_ptr <= (g+1) mod NUM_REQ. Next state ISSUE.
  - With no request pending, remain in IDLE.
- ISSUE:
  - Exactly one of read_ena/write_ena is high, matching the latched op. It is asserted from the first ISSUE cycle, i.e. 1 cycle after req_ready.
  - The counter increments every ISSUE cycle.
  - On the matching done pulse (read_done for reads, write_done for writes):
    - ena <= 0.
    - rsp_valid[g] pulses next cycle.
    - rsp_rdata = read_data captured at the done cycle for reads, 0 for writes; rsp_err=0.
    - Next state RELEASE.
  - A non-matching done pulse is ignored.
  - If the counter reaches TIMEOUT_CYC (TIMEOUT_CYC>0) with no done:
    - ena <= 0, rsp_valid[g] pulses, rsp_err=1, rsp_rdata=0.
    - Next state RELEASE.
  - If done and timeout coincide, done wins.
- RELEASE:
  - Both enables 0 for exactly one cycle; addresses and write_data cleared to 0; counter cleared.
  - Next state IDLE. No grant is made in RELEASE.
  - This guarantees the engine resets to its address state and issues no duplicate transaction.
- Throughput: one transaction per (engine latency + 3) cycles minimum.
- Handshake rules:
  - A requester must hold req_valid and its fields stable until it sees req_ready.
  - Deasserting req_valid before grant is legal; the request is simply not taken.
  - req_valid rising again in the cycle rsp_valid fires is legal and is arbitrated normally in the next IDLE.
- Width: the counter is clog2(TIMEOUT_CYC+1) bits, minimum 1, and saturates (cannot wrap).

Decomposition:
- Shared package axil_arb_pkg: state enum (IDLE=2'd0, ISSUE=2'd1, RELEASE=2'd2), op encoding (OP_RD=0, OP_WR=1), and a clog2 helper function.
- One sub-module, rr_grant. It is combinational: it takes req_valid and rr_ptr and outputs a one-hot grant plus the grant index. It is parameterized by NUM_REQ and reusable elsewhere.

Test Plan:
- Single read:
  - Stimulus: req_valid=4'b0001, req_write=0, addr0=0x40; engine model returns read_done 5 cycles after read_ena with read_data=0xDEADBEEF.
  - Required response: req_ready[0] in cycle 0; read_ena high cycles 1-6; rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF and rsp_err=0; one RELEASE cycle with both enables low.
- Round robin:
  - Stimulus: all four requesters hold valid continuously.
  - Required response: grant order 0,1,2,3,0. No requester is granted twice before the others are granted once.
- Mixed read/write:
  - Stimulus: req1 writes 0x12345678 to 0x10 while req2 reads 0x20.
  - Required response: write_ena only with write_addr=0x10 and write_data=0x12345678, rsp_rdata=0 for the write; then read_ena only with read_addr=0x20.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16; engine never pulses done.
  - Required response: ena drops after 16 ISSUE cycles; rsp_valid pulses with rsp_err=1 and rsp_rdata=0; the next requester is then served.
- Done/timeout collision:
  - Stimulus: read_done arrives in the exact cycle the counter hits TIMEOUT_CYC.
  - Required response: rsp_err=0 and rsp_rdata=read_data.
- Reset mid-ISSUE:
  - Stimulus: assert m_axi_areset during a write.
  - Required response: all outputs 0 immediately (asynchronous); no rsp_valid; after release the first grant is requester 0 if its valid is high.
